// File: rtl/tdm_demux_if.sv
// Stream port bundle for the TDM receive demultiplexer: serial input beats
// on one side, per-channel registers and alignment status on the other.
interface tdm_demux_if #(
  parameter int WIDTH = 8,
  parameter int SELW  = 2
);
  localparam int NCH = 2**SELW;

  logic [WIDTH-1:0]     in_data;
  logic                 in_valid;
  logic                 in_sof;
  logic [NCH*WIDTH-1:0] out_data;
  logic [NCH-1:0]       out_valid;
  logic                 frame_done;
  logic                 locked;
  logic                 sync_err;

  modport master (
    output in_data, in_valid, in_sof,
    input  out_data, out_valid, frame_done, locked, sync_err
  );

  modport slave (
    input  in_data, in_valid, in_sof,
    output out_data, out_valid, frame_done, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux.sv
// TDM receive demux: registers incoming beats, tracks slot alignment
// (HUNT/LOCKED) and steers each word into its channel holding register.
module tdm_demux_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module tdm_demux #(
  parameter int WIDTH = 8,
  parameter int SELW  = 2
) (
  input logic         clk,
  input logic         rst_n,
  tdm_demux_if.slave  bus
);
  localparam int NCH = 2**SELW;
  localparam logic [SELW-1:0] LAST = SELW'(NCH-1);
  localparam logic [SELW-1:0] ONE  = SELW'(1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                          state, state_nxt;
  logic [SELW-1:0]                 cnt, cnt_nxt;
  logic                            s0_vld, s0_sof;
  logic [WIDTH-1:0]                s0_data;
  logic                            wr_en, err_nxt, fd_nxt;
  logic [SELW-1:0]                 wr_sel;
  logic [NCH-1:0]                  wr_oh;
  logic [NCH-1:0][WIDTH-1:0]       ch_q;
  logic [NCH-1:0]                  ov_q;
  logic                            fd_q, err_q, lck_q;

  // Input capture stage; the alignment FSM works on the registered beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld  <= 1'b0;
      s0_sof  <= 1'b0;
      s0_data <= '0;
    end else begin
      s0_vld  <= bus.in_valid;
      s0_sof  <= bus.in_valid & bus.in_sof;
      s0_data <= bus.in_data;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    err_nxt   = 1'b0;
    fd_nxt    = 1'b0;
    if (s0_vld) begin
      case (state)
        HUNT: if (s0_sof) begin
          wr_en     = 1'b1;
          cnt_nxt   = ONE;
          state_nxt = LOCKED;
        end
        LOCKED: begin
          if (s0_sof) begin
            // early sof abandons the partial frame but keeps lock
            wr_en   = 1'b1;
            cnt_nxt = ONE;
            err_nxt = (cnt != '0);
          end else if (cnt == '0) begin
            err_nxt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = HUNT;
          end else begin
            wr_en   = 1'b1;
            cnt_nxt = cnt + ONE;
            fd_nxt  = (cnt == LAST);
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  assign wr_sel = s0_sof ? '0 : cnt;

  always_comb begin
    wr_oh = '0;
    if (wr_en) wr_oh[wr_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      cnt   <= '0;
      ov_q  <= '0;
      fd_q  <= 1'b0;
      err_q <= 1'b0;
      lck_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ov_q  <= wr_oh;
      fd_q  <= fd_nxt;
      err_q <= err_nxt;
      lck_q <= (state_nxt == LOCKED);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    tdm_demux_ch #(.WIDTH(WIDTH)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_oh[k]),
      .d     (s0_data),
      .q     (ch_q[k])
    );
  end

  assign bus.out_data   = ch_q;
  assign bus.out_valid  = ov_q;
  assign bus.frame_done = fd_q;
  assign bus.sync_err   = err_q;
  assign bus.locked     = lck_q;
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: the receive end of the channel-select/mux path.
- Accepts one word-serial stream in which consecutive valid beats carry channels 0..NCH-1 in fixed slot order. A start-of-frame marker flags slot 0.
- Steers each word into a per-channel holding register and raises a one-cycle strobe for that channel.
- Tracks frame alignment: hunts for sync, locks, flags and recovers from misalignment.

Parameters:
- WIDTH, 8, data word width in bits.
- SELW, 2, slot-index width. NCH = 2**SELW channels (legal SELW 1..4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  time-multiplexed data word.
- in_valid  input  1  beat qualifier; in_data/in_sof sampled only when high.
- in_sof  input  1  start of frame; marks the current beat as slot 0.
- out_data  output  NCH*WIDTH  packed channel registers; channel k at [k*WIDTH +: WIDTH].
- out_valid  output  NCH  one-hot one-cycle strobe; bit k = channel k updated this cycle.
- frame_done  output  1  one-cycle pulse, coincident with out_valid[NCH-1].
- locked  output  1  high while in LOCKED state.
- sync_err  output  1  one-cycle pulse per alignment error.

Behaviour:
- Reset (rst_n low, async): state=HUNT, slot counter=0, out_data=0, out_valid=0, frame_done=0, locked=0, sync_err=0. All state clears immediately, including mid-frame; the first post-reset beat is handled as HUNT.
- All outputs are registered. An accepted beat at edge N appears on out_data/out_valid after edge N+1 (1-cycle latency). out_data[k] holds its value until channel k is next written.
- A beat is any cycle with in_valid=1. in_sof is ignored when in_valid=0. No backpressure: every beat must be consumed.
- States: HUNT, LOCKED. The slot counter is SELW bits, wraps NCH-1 -> 0.
- HUNT, beat without sof: discard; no strobe; stay in HUNT.
- HUNT, beat with sof: write channel 0, out_valid[0] strobe, counter=1, go to LOCKED. locked=1 from the next cycle.
- LOCKED, beat, counter=c!=0, no sof: write channel c, strobe out_valid[c], counter=c+1 (wraps). If c=NCH-1, pulse frame_done with the strobe.
- LOCKED, beat, counter=0, sof: normal slot 0. Write channel 0, counter=1.
- LOCKED, beat, counter!=0, sof (early frame): pulse sync_err. Abandon the partial frame (no frame_done). Write channel 0, counter=1, stay LOCKED.
- LOCKED, beat, counter=0, no sof (missing sync): pulse sync_err. Discard the word, no strobe. Go to HUNT, counter=0, locked=0.
- sync_err is registered, same latency as out_valid.
- Idle cycles (in_valid=0) between beats are allowed anywhere. Counter and state hold; out_valid, frame_done and sync_err are 0.
- NCH=2 (SELW=1) is legal: frame_done follows every slot-1 write.

Test Plan (WIDTH=8, SELW=2):
- Reset then beats A0(sof),A1,A2,A3 back-to-back -> out_valid 0001,0010,0100,1000 on cycles 1-4 after each beat; out_data={A3,A2,A1,A0}; frame_done only with 1000; locked=1 from after the first beat.
- Beats 11,22 (no sof) in HUNT, then 33(sof) -> no strobes for 11/22; channel 0=0x33, locked rises; sync_err stays 0.
- Locked; beats 0x10(sof),0x11, then 0x20(sof) at slot 2 -> sync_err one pulse; channel 0=0x20; channel 2 unchanged; no frame_done; next beat 0x21 -> out_valid 0010.
- Locked after a full frame; next beat 0x55 without sof -> sync_err pulse, no out_valid, locked=0; following 0x66(sof) -> relock, channel 0=0x66.
- Full frame with 3 idle cycles between each beat -> same out_data as the back-to-back case; exactly 4 strobes; out_valid=0 during idles.
- Assert rst_n low asynchronously mid-frame (after slot 1) -> out_data/out_valid/locked clear without a clock edge; next beat with sof restarts at channel 0.
